// File: rtl/ft_mem_pkg.sv
// Shared types and helpers for the checkpoint memory: FSM encoding, parity
// generation and the word index that holds the PC.
package ft_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        DONE = 2'd2
    } ckpt_state_e;

    // Widest data word par_f accepts; callers zero-extend, which leaves parity unchanged.
    localparam int unsigned PAR_MAX_W = 64;

    function automatic logic par_f(input logic [PAR_MAX_W-1:0] data);
        return ^data;
    endfunction

    // The PC sits directly after the architectural registers.
    function automatic int unsigned pc_index_f(input int unsigned num_regs);
        return num_regs;
    endfunction

endpackage

// File: rtl/ft_par_bank.sv
// One parity-protected register bank: a general write port, a dedicated
// write lane for the top (PC) word, and a combinational read port.
module ft_par_bank #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 33,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [DATA_W:0] wdata_i,
    input  logic            top_we_i,
    input  logic [DATA_W:0] top_wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [DATA_W:0] rdata_o
);

    logic [DATA_W:0] rd_words [DEPTH];

    // Each word is a discrete flop so that the whole bank clears on reset.
    for (genvar gi = 0; gi < int'(DEPTH); gi++) begin : g_word
        logic [DATA_W:0] word_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                word_q <= '0;
            end else if (top_we_i && (gi == int'(DEPTH) - 1)) begin
                word_q <= top_wdata_i;
            end else if (we_i && (waddr_i == AW'(gi))) begin
                word_q <= wdata_i;
            end
        end

        assign rd_words[gi] = word_q;
    end

    assign rdata_o = (raddr_i < AW'(DEPTH)) ? rd_words[raddr_i] : '0;

endmodule

// File: rtl/ft_ckpt_mem.sv
// Double-banked checkpoint memory: captures RF/PC writes into a working bank,
// copies it word by word into a committed bank on commit, and serves reads.
module ft_ckpt_mem
    import ft_mem_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned RF_AW    = $clog2(NUM_REGS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_rf_i,
    input  logic [RF_AW-1:0]  addr_rf_i,
    input  logic [DATA_W-1:0] data_rf_i,
    input  logic              load_pc_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic              commit_i,
    output logic              busy_o,
    output logic              commit_done_o,
    output logic              wr_drop_o,
    input  logic              req_i,
    output logic              gnt_o,
    input  logic [31:0]       addr_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o
);

    localparam int unsigned DEPTH = NUM_REGS + 1;
    localparam int unsigned WAW   = $clog2(DEPTH);
    localparam logic [WAW-1:0] PC_IDX = WAW'(pc_index_f(NUM_REGS));

    ckpt_state_e       state_q, state_next;
    logic [WAW-1:0]    idx_q;
    logic              wr_drop_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [DATA_W:0]   work_word;
    logic [DATA_W:0]   cmt_word;
    logic [WAW-1:0]    rd_idx;
    logic              rd_oob;
    logic              commit_accept;
    logic              unused_addr;

    assign busy_o        = (state_q != IDLE);
    assign commit_done_o = (state_q == DONE);
    assign wr_drop_o     = wr_drop_q;
    assign gnt_o         = req_i & ~busy_o;
    assign commit_accept = (state_q == IDLE) & commit_i;

    assign rd_idx      = addr_i[WAW+1:2];
    assign rd_oob      = addr_i[31:2] > 30'(NUM_REGS);
    assign unused_addr = ^addr_i[1:0];

    ft_par_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(WAW)) u_work_bank (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .we_i        (we_rf_i & ~busy_o),
        .waddr_i     (WAW'(addr_rf_i)),
        .wdata_i     ({par_f(PAR_MAX_W'(data_rf_i)), data_rf_i}),
        .top_we_i    (load_pc_i & ~busy_o),
        .top_wdata_i ({par_f(PAR_MAX_W'(pc_i)), pc_i}),
        .raddr_i     (idx_q),
        .rdata_o     (work_word)
    );

    // The copy moves data and parity verbatim so a latent fault stays detectable.
    ft_par_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(WAW)) u_cmt_bank (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .we_i        (state_q == COPY),
        .waddr_i     (idx_q),
        .wdata_i     (work_word),
        .top_we_i    (1'b0),
        .top_wdata_i ('0),
        .raddr_i     (rd_idx),
        .rdata_o     (cmt_word)
    );

    always_comb begin
        state_next = state_q;
        case (state_q)
            IDLE:    if (commit_i) state_next = COPY;
            COPY:    if (idx_q == PC_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q <= state_next;
            if (commit_accept) begin
                idx_q     <= '0;
                wr_drop_q <= 1'b0;
            end else begin
                if (state_q == COPY) idx_q <= idx_q + 1'b1;
                if (busy_o && (we_rf_i || load_pc_i)) wr_drop_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= gnt_o;
            if (gnt_o) begin
                if (rd_oob) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end else begin
                    rdata_q <= cmt_word[DATA_W-1:0];
                    err_q   <= cmt_word[DATA_W] ^ par_f(PAR_MAX_W'(cmt_word[DATA_W-1:0]));
                end
            end
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_ft_ckpt_mem.sv
// Randomized bench for ft_ckpt_mem against a two-array snapshot model.
module tb_ft_ckpt_mem;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int RF_AW    = 5;
    localparam int DEPTH    = NUM_REGS + 1;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              we_rf_i;
    logic [RF_AW-1:0]  addr_rf_i;
    logic [DATA_W-1:0] data_rf_i;
    logic              load_pc_i;
    logic [DATA_W-1:0] pc_i;
    logic              commit_i;
    logic              busy_o;
    logic              commit_done_o;
    logic              wr_drop_o;
    logic              req_i;
    logic              gnt_o;
    logic [31:0]       addr_i;
    logic              rvalid_o;
    logic [DATA_W-1:0] rdata_o;
    logic              err_o;

    always #5 clk_i = ~clk_i;

    ft_ckpt_mem #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RF_AW(RF_AW)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .we_rf_i       (we_rf_i),
        .addr_rf_i     (addr_rf_i),
        .data_rf_i     (data_rf_i),
        .load_pc_i     (load_pc_i),
        .pc_i          (pc_i),
        .commit_i      (commit_i),
        .busy_o        (busy_o),
        .commit_done_o (commit_done_o),
        .wr_drop_o     (wr_drop_o),
        .req_i         (req_i),
        .gnt_o         (gnt_o),
        .addr_i        (addr_i),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o)
    );

    // Reference model: what software would see in each bank.
    logic [31:0] work_m [DEPTH];
    logic [31:0] cmt_m  [DEPTH];
    bit          drop_m;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            work_m[i] = '0;
            cmt_m[i]  = '0;
        end
        drop_m = 1'b0;
    endtask

    task automatic do_write(input bit we, input logic [4:0] a, input logic [31:0] d,
                            input bit lp, input logic [31:0] pc);
        @(negedge clk_i);
        we_rf_i = we; addr_rf_i = a; data_rf_i = d;
        load_pc_i = lp; pc_i = pc;
        @(posedge clk_i); #1;
        we_rf_i = 1'b0; load_pc_i = 1'b0;
        if (we) work_m[a] = d;
        if (lp) work_m[NUM_REGS] = pc;
        $display("write we=%0b x%0d=%h lp=%0b pc=%h", we, a, d, lp, pc);
    endtask

    task automatic do_read(input logic [31:0] addr);
        logic [31:0] idx, exp_d;
        logic        exp_e;
        idx = addr >> 2;
        if (idx > NUM_REGS) begin
            exp_d = '0; exp_e = 1'b1;
        end else begin
            exp_d = cmt_m[idx]; exp_e = 1'b0;
        end
        @(negedge clk_i);
        req_i = 1'b1; addr_i = addr;
        #1 check("rd_gnt", gnt_o, 1);
        @(posedge clk_i); #1;
        req_i = 1'b0;
        check("rd_rvalid", rvalid_o, 1);
        check("rd_data", rdata_o, exp_d);
        check("rd_err", err_o, exp_e);
        @(posedge clk_i); #1;
        check("rd_rvalid_drop", rvalid_o, 0);
        check("rd_data_hold", rdata_o, exp_d);
        $display("read addr=%h data=%h err=%0b", addr, rdata_o, err_o);
    endtask

    // Commit with a read in the same cycle (must see the old snapshot);
    // optionally hammer writes and reads during the copy.
    task automatic do_commit(input bit disturb);
        logic [31:0] ra, exp_old;
        int busy_cycles, done_cnt;
        ra = $urandom_range(0, NUM_REGS) << 2;
        exp_old = cmt_m[ra >> 2];
        @(negedge clk_i);
        commit_i = 1'b1; req_i = 1'b1; addr_i = ra;
        #1 check("commit_rd_gnt", gnt_o, 1);
        @(posedge clk_i); #1;
        commit_i = 1'b0; req_i = 1'b0;
        check("commit_rd_rvalid", rvalid_o, 1);
        check("commit_rd_old", rdata_o, exp_old);
        cmt_m = work_m;
        drop_m = 1'b0;
        busy_cycles = 0;
        done_cnt = 0;
        while (busy_o && busy_cycles < 100) begin
            busy_cycles++;
            if (commit_done_o) done_cnt++;
            @(negedge clk_i);
            if (disturb) begin
                we_rf_i = $urandom_range(0, 1); load_pc_i = $urandom_range(0, 1);
                addr_rf_i = RF_AW'($urandom); data_rf_i = $urandom; pc_i = $urandom;
                commit_i = $urandom_range(0, 1);
                req_i = 1'b1; addr_i = $urandom_range(0, NUM_REGS) << 2;
                if (we_rf_i || load_pc_i) drop_m = 1'b1;
                #1 check("busy_gnt", gnt_o, 0);
            end
            @(posedge clk_i); #1;
            we_rf_i = 1'b0; load_pc_i = 1'b0; req_i = 1'b0; commit_i = 1'b0;
        end
        check("busy_len", busy_cycles, NUM_REGS + 2);
        check("done_pulses", done_cnt, 1);
        check("done_low_idle", commit_done_o, 0);
        check("wr_drop", wr_drop_o, drop_m);
        $display("commit disturb=%0b busy=%0d drop=%0b", disturb, busy_cycles, wr_drop_o);
    endtask

    initial begin
        rst_ni = 1'b1;
        we_rf_i = 0; addr_rf_i = '0; data_rf_i = '0; load_pc_i = 0; pc_i = '0;
        commit_i = 0; req_i = 0; addr_i = '0;
        clear_model();
        #2 rst_ni = 1'b0;
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_done", commit_done_o, 0);
        check("rst_drop", wr_drop_o, 0);
        check("rst_rvalid", rvalid_o, 0);
        check("rst_err", err_o, 0);
        check("rst_rdata", rdata_o, 0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i) rst_ni = 1'b1;

        do_read(32'h14);

        do_write(1, 5'd7, 32'hDEADBEEF, 1, 32'h00000080);
        do_commit(0);
        do_read(32'h1C);
        do_read(32'h80);

        do_write(1, 5'd3, 32'h11, 0, '0);
        do_commit(1);
        do_read(32'h0C);
        do_read(32'h84);
        do_read(32'hFFFF_FFF0);

        for (int it = 0; it < 15; it++) begin
            int nw;
            nw = $urandom_range(1, 4);
            for (int w = 0; w < nw; w++)
                do_write($urandom_range(0, 1), RF_AW'($urandom), $urandom,
                         $urandom_range(0, 1), $urandom);
            do_commit($urandom_range(0, 1));
            for (int r = 0; r < 4; r++) begin
                if ($urandom_range(0, 3) == 0) do_read($urandom);
                else do_read(($urandom_range(0, NUM_REGS) << 2) | $urandom_range(0, 3));
            end
        end

        // Corrupt committed x1: data 1 with parity 0 is an odd-parity word.
        @(negedge clk_i);
        force dut.u_cmt_bank.g_word[1].word_q = 33'h0_0000_0001;
        req_i = 1'b1; addr_i = 32'h4;
        @(posedge clk_i); #1;
        req_i = 1'b0;
        check("par_rvalid", rvalid_o, 1);
        check("par_data", rdata_o, 32'h1);
        check("par_err", err_o, 1);
        $display("read addr=%h data=%h err=%0b (corrupted)", 32'h4, rdata_o, err_o);
        release dut.u_cmt_bank.g_word[1].word_q;

        do_write(1, 5'd9, 32'h1234_5678, 1, 32'h400);
        @(negedge clk_i) commit_i = 1'b1;
        @(posedge clk_i); #1 commit_i = 1'b0;
        @(negedge clk_i) we_rf_i = 1'b1;
        @(posedge clk_i); #1 we_rf_i = 1'b0;
        repeat (9) @(posedge clk_i);
        #1;
        check("pre_rst_busy", busy_o, 1);
        check("pre_rst_drop", wr_drop_o, 1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_done", commit_done_o, 0);
        check("mid_rst_drop", wr_drop_o, 0);
        check("mid_rst_rvalid", rvalid_o, 0);
        check("mid_rst_err", err_o, 0);
        check("mid_rst_rdata", rdata_o, 0);
        clear_model();
        @(negedge clk_i) rst_ni = 1'b1;
        for (int i = 0; i < DEPTH; i++) do_read(i << 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ft_ckpt_mem.md
# ft_ckpt_mem

Parametrised, double-banked checkpoint memory for the fault-tolerant core pair. It captures register-file writes and PC loads into a working bank, then copies the working bank into a committed bank word by word when a commit is requested. Recovery logic reads the committed snapshot through an OBI-style req/gnt/rvalid port. Every stored word carries even parity; reads report parity or address faults on `err_o`.

## Interface
- `DATA_W`, 32: width of register, PC and read data.
- `NUM_REGS`, 32: number of architectural registers checkpointed. The PC occupies word index `NUM_REGS`.
- `RF_AW`, `$clog2(NUM_REGS)`: register-file address width (derived).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `we_rf_i`  in  1  register write into working bank.
- `addr_rf_i`  in  RF_AW  register index.
- `data_rf_i`  in  DATA_W  register write data.
- `load_pc_i`  in  1  PC write into working bank, index `NUM_REGS`.
- `pc_i`  in  DATA_W  PC value.
- `commit_i`  in  1  request copy of working bank into committed bank.
- `busy_o`  out  1  copy in progress.
- `commit_done_o`  out  1  one-cycle pulse when the copy finishes.
- `wr_drop_o`  out  1  sticky flag: a write arrived while busy and was dropped.
- `req_i`  in  1  read request.
- `gnt_o`  out  1  read grant.
- `addr_i`  in  32  byte address; word index = `addr_i >> 2`.
- `rvalid_o`  out  1  read data valid.
- `rdata_o`  out  DATA_W  read data from committed bank.
- `err_o`  out  1  read fault, qualified by `rvalid_o`.

## Operation
- Storage: two banks of `NUM_REGS+1` words. Each word is `DATA_W` data bits plus 1 even-parity bit. All words reset to 0 with parity 0.
- Working-bank writes in IDLE:
  - `we_rf_i` writes `data_rf_i` to `addr_rf_i`.
  - `load_pc_i` writes `pc_i` to index `NUM_REGS`.
  - Both may occur in the same cycle.
  - Parity is generated on write.
- FSM states IDLE, COPY, DONE.
  - IDLE: `commit_i` moves to COPY and clears the copy index to 0. `wr_drop_o` is cleared in the same cycle.
  - COPY: each cycle copies working[idx], data and parity unchanged, into committed[idx], then increments idx. After idx = `NUM_REGS` is copied, move to DONE.
  - DONE: `commit_done_o` = 1 for this cycle only, then return to IDLE.
- `busy_o` = 1 in COPY and DONE.
- `commit_i` in COPY or DONE is ignored, with no queuing.
- A working-bank write while `busy_o` = 1 is discarded and sets `wr_drop_o`. The flag holds until the next accepted commit.
- Read port: `gnt_o = req_i & ~busy_o`, combinational.
  - Granted read of index ≤ `NUM_REGS`: returns committed[index]. `err_o` = 1 if the stored parity mismatches.
  - Index > `NUM_REGS`: `rdata_o` = 0, `err_o` = 1.
- Reset mid-COPY: state returns to IDLE and both banks clear to 0. The partially copied snapshot is not preserved.

## Timing
- Reset values:
  - `busy_o`, `commit_done_o`, `wr_drop_o`, `rvalid_o`, `err_o` = 0.
  - `rdata_o` = 0.
  - FSM in IDLE.
- Write latency: a working-bank write is visible to the copy on the next clock edge.
- Commit latency: `commit_i` sampled at edge 0.
  - `busy_o` high from edge 0.
  - Copies occur at edges 1 … `NUM_REGS+1`.
  - `commit_done_o` high between edges `NUM_REGS+1` and `NUM_REGS+2`.
  - IDLE again after edge `NUM_REGS+2`.
  - Total: `NUM_REGS+2` cycles busy.
- Read latency: a grant at edge N gives `rvalid_o`, `rdata_o` and `err_o` valid after edge N+1, for one cycle. Back-to-back reads are allowed every cycle.
- `rdata_o` and `err_o` hold their last values when `rvalid_o` = 0.
- A read granted in the same cycle as an accepted `commit_i` returns the pre-commit committed word.

## Structure
- Package `ft_mem_pkg`:
  - FSM enum `ckpt_state_e` (IDLE, COPY, DONE).
  - Function `par_f` (even parity over `DATA_W`).
  - PC index convention: PC at word `NUM_REGS`.
- Sub-module `ft_par_bank`: one parity-protected register bank with one write port and one read port. Instantiated twice: working and committed.

## Test plan
- Reset, then read index 5 → `rvalid_o` = 1 one cycle after grant, `rdata_o` = 0, `err_o` = 0.
- Write x7 = 0xDEADBEEF and PC = 0x00000080, commit, wait for `commit_done_o`, read addr 0x1C and addr 0x80 → 0xDEADBEEF and 0x00000080. `busy_o` lasts exactly 34 cycles (default `NUM_REGS` = 32).
- Write x3 = 0x11 and commit. During COPY, write x3 = 0x22 and hold `req_i` → `gnt_o` = 0 throughout, `wr_drop_o` = 1, committed x3 reads 0x11 after done.
- Read addr 0x84 (index 33) → `rdata_o` = 0, `err_o` = 1.
- Force-flip one data bit of committed x1 → next read of x1 gives `err_o` = 1.
- Assert `rst_ni` low at copy index 10 → all outputs 0 immediately, and every committed word reads 0 after release.
